// File: rtl/dht_frame_reader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dht_frame_reader_pkg : shared states, error codes, frame helpers    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package dht_frame_reader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_START_LOW = 4'd1,
    ST_RELEASE   = 4'd2,
    ST_RESP_LOW  = 4'd3,
    ST_RESP_HIGH = 4'd4,
    ST_BIT_LOW   = 4'd5,
    ST_BIT_HIGH  = 4'd6,
    ST_FINISH    = 4'd7,
    ST_ERR       = 4'd8
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_NORESP  = 2'd1;
  localparam logic [1:0] ERR_RESP_TO = 2'd2;
  localparam logic [1:0] ERR_BIT_TO  = 2'd3;

  localparam int FRAME_BITS = 40;

  // 8-bit sum of the four payload bytes, carry dropped, against the sum byte
  function automatic logic frame_crc_ok(input logic [39:0] f);
    logic [7:0] sum;
    sum = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    return (sum == f[7:0]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dht_frame_reader_us_tick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | us_tick_gen : divides clk by CLK_MHZ into a 1 us strobe             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module us_tick_gen #(
  parameter int CLK_MHZ = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int             CW     = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
  localparam logic [CW-1:0]  c_last = CW'(CLK_MHZ - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (r_cnt == c_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/dht_frame_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dht_frame_reader : single-wire DHT11/DHT22 frame reader            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module dht_frame_reader
  import dht_frame_reader_pkg::*;
#(
  parameter int CLK_MHZ       = 50,
  parameter int START_LOW_US  = 1000,
  parameter int BIT_THRESH_US = 50,
  parameter int TIMEOUT_US    = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        wire_in,
  output logic        wire_out,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [39:0] data,
  output logic        crc_ok
);

  localparam logic [15:0] c_start_low = 16'(START_LOW_US);
  localparam logic [15:0] c_thresh    = 16'(BIT_THRESH_US);
  localparam logic [15:0] c_timeout   = 16'(TIMEOUT_US);
  localparam logic [5:0]  c_last_bit  = 6'(FRAME_BITS - 1);

  state_t      r_state, w_next;
  logic [1:0]  w_err_load;
  logic        r_sync1, r_sync2, r_prev;
  logic        w_rise, w_fall;
  logic        w_tick, w_enter;
  logic [15:0] r_us_cnt, w_elapsed;
  logic [39:0] r_shift, w_shifted;
  logic [5:0]  r_bit_cnt;
  logic        w_bit;

  us_tick_gen #(.CLK_MHZ(CLK_MHZ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_enter),
    .tick (w_tick)
  );

  assign w_rise = ~r_prev & r_sync2;
  assign w_fall = r_prev & ~r_sync2;

  // Microseconds spent in the state including the current cycle; this makes
  // a high phase of exactly N us measure as N when its falling edge arrives.
  assign w_elapsed = (r_us_cnt == 16'hFFFF) ? 16'hFFFF : r_us_cnt + {15'd0, w_tick};
  assign w_enter   = (w_next != r_state);
  assign w_bit     = (w_elapsed >= c_thresh);
  assign w_shifted = {r_shift[38:0], w_bit};

  always_comb begin
    w_next     = r_state;
    w_err_load = ERR_NONE;
    case (r_state)
      ST_IDLE:      if (start) w_next = ST_START_LOW;
      ST_START_LOW: if (w_elapsed >= c_start_low) w_next = ST_RELEASE;
      ST_RELEASE: begin
        if (w_fall) w_next = ST_RESP_LOW;
        else if (w_elapsed >= c_timeout) begin
          w_next     = ST_ERR;
          w_err_load = ERR_NORESP;
        end
      end
      ST_RESP_LOW: begin
        if (w_rise) w_next = ST_RESP_HIGH;
        else if (w_elapsed >= c_timeout) begin
          w_next     = ST_ERR;
          w_err_load = ERR_RESP_TO;
        end
      end
      ST_RESP_HIGH: begin
        if (w_fall) w_next = ST_BIT_LOW;
        else if (w_elapsed >= c_timeout) begin
          w_next     = ST_ERR;
          w_err_load = ERR_RESP_TO;
        end
      end
      ST_BIT_LOW: begin
        if (w_rise) w_next = ST_BIT_HIGH;
        else if (w_elapsed >= c_timeout) begin
          w_next     = ST_ERR;
          w_err_load = ERR_BIT_TO;
        end
      end
      ST_BIT_HIGH: begin
        if (w_fall) w_next = (r_bit_cnt == c_last_bit) ? ST_FINISH : ST_BIT_LOW;
        else if (w_elapsed >= c_timeout) begin
          w_next     = ST_ERR;
          w_err_load = ERR_BIT_TO;
        end
      end
      ST_FINISH:    w_next = ST_IDLE;
      ST_ERR:       w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    wire_out = (r_state != ST_START_LOW);
    busy     = (r_state != ST_IDLE) && (r_state != ST_FINISH) && (r_state != ST_ERR);
    done     = (r_state == ST_FINISH);
    error    = (r_state == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_prev    <= 1'b1;
      r_us_cnt  <= 16'd0;
      r_shift   <= 40'd0;
      r_bit_cnt <= 6'd0;
      data      <= 40'd0;
      crc_ok    <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      r_sync1 <= wire_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_state <= w_next;

      if (w_enter) r_us_cnt <= 16'd0;
      else if (w_tick && (r_us_cnt != 16'hFFFF)) r_us_cnt <= r_us_cnt + 16'd1;

      if ((r_state == ST_IDLE) && start) err_code <= ERR_NONE;
      if (w_enter && (w_next == ST_ERR)) err_code <= w_err_load;

      if ((r_state == ST_RESP_HIGH) && w_fall) r_bit_cnt <= 6'd0;

      // Frame is published on the way into FINISH so it is valid while done is high
      if ((r_state == ST_BIT_HIGH) && w_fall) begin
        r_shift   <= w_shifted;
        r_bit_cnt <= r_bit_cnt + 6'd1;
        if (r_bit_cnt == c_last_bit) begin
          data   <= w_shifted;
          crc_ok <= frame_crc_ok(w_shifted);
        end
      end
    end
  end

endmodule
`default_nettype wire
